// File: rtl/sample_scheduler.sv
// Sample scheduler: sends each input sample to an external DSP engine and emits
// the engine result, or the dry input if the engine misses its deadline.
module sample_scheduler #(
    parameter int data_width     = 16,
    parameter int timeout_cycles = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [data_width-1:0] in_sample,
    input  logic                  in_valid,
    input  logic                  clear_stats,
    output logic [data_width-1:0] eng_sample,
    output logic                  eng_sample_ready,
    input  logic                  eng_ready,
    input  logic [data_width-1:0] eng_out_sample,
    output logic [data_width-1:0] out_sample,
    output logic                  out_valid,
    output logic                  bypass,
    output logic                  busy,
    output logic [15:0]           overrun_count,
    output logic [15:0]           timeout_count
);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACCEPT,
        WAIT_DONE,
        EMIT
    } state_t;

    localparam logic [15:0] last_wait = 16'(timeout_cycles - 1);
    localparam logic [15:0] cnt_max   = 16'hFFFF;

    state_t      state;
    logic [15:0] wait_cnt;
    logic        waiting;
    logic        exit_cond;
    logic        at_deadline;
    logic        timed_out;
    logic        dropped;

    assign waiting = (state == WAIT_ACCEPT) || (state == WAIT_DONE);

    always_comb begin
        exit_cond = 1'b0;
        case (state)
            WAIT_ACCEPT: exit_cond = !eng_ready;
            WAIT_DONE:   exit_cond = eng_ready;
            default:     exit_cond = 1'b0;
        endcase
    end

    // >= rather than == so an accept landing exactly on the deadline still
    // leaves WAIT_DONE bounded instead of waiting for the counter to wrap.
    assign at_deadline = (wait_cnt >= last_wait);
    assign timed_out   = waiting && at_deadline && !exit_cond;
    assign dropped     = in_valid && (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            wait_cnt         <= '0;
            eng_sample       <= '0;
            eng_sample_ready <= 1'b0;
            out_sample       <= '0;
            out_valid        <= 1'b0;
            bypass           <= 1'b0;
            busy             <= 1'b0;
        end else begin
            eng_sample_ready <= 1'b0;
            out_valid        <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        eng_sample       <= in_sample;
                        eng_sample_ready <= 1'b1;
                        busy             <= 1'b1;
                        state            <= ISSUE;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT_ACCEPT;
                end
                WAIT_ACCEPT: begin
                    wait_cnt <= wait_cnt + 16'd1;
                    if (exit_cond) begin
                        state <= WAIT_DONE;
                    end else if (timed_out) begin
                        out_sample <= eng_sample;
                        bypass     <= 1'b1;
                        out_valid  <= 1'b1;
                        state      <= EMIT;
                    end
                end
                WAIT_DONE: begin
                    wait_cnt <= wait_cnt + 16'd1;
                    if (exit_cond) begin
                        out_sample <= eng_out_sample;
                        bypass     <= 1'b0;
                        out_valid  <= 1'b1;
                        state      <= EMIT;
                    end else if (timed_out) begin
                        out_sample <= eng_sample;
                        bypass     <= 1'b1;
                        out_valid  <= 1'b1;
                        state      <= EMIT;
                    end
                end
                EMIT: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Clear outranks a same-cycle increment; both counters stick at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overrun_count <= '0;
        end else if (clear_stats) begin
            overrun_count <= '0;
        end else if (dropped && overrun_count != cnt_max) begin
            overrun_count <= overrun_count + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_count <= '0;
        end else if (clear_stats) begin
            timeout_count <= '0;
        end else if (timed_out && timeout_count != cnt_max) begin
            timeout_count <= timeout_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_sample_scheduler.sv
// Bench for sample_scheduler: a default-timeout instance and a timeout_cycles=8
// instance share stimulus; sel picks which one a scenario observes.
module tb_sample_scheduler;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        clear_stats = 1'b0;
    logic        eng_ready = 1'b1;
    logic [15:0] in_sample = '0;
    logic [15:0] eng_out_sample = '0;

    logic [15:0] eng_sample_w [2];
    logic [15:0] out_sample_w [2];
    logic [15:0] ovr_w [2];
    logic [15:0] tmo_w [2];
    logic        esr_w [2];
    logic        ov_w [2];
    logic        byp_w [2];
    logic        busy_w [2];

    int sel = 0;
    int n_total = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sample_scheduler #(.data_width(16)) dut_d (
        .clk(clk), .reset(reset), .in_sample(in_sample), .in_valid(in_valid),
        .clear_stats(clear_stats), .eng_sample(eng_sample_w[0]),
        .eng_sample_ready(esr_w[0]), .eng_ready(eng_ready),
        .eng_out_sample(eng_out_sample), .out_sample(out_sample_w[0]),
        .out_valid(ov_w[0]), .bypass(byp_w[0]), .busy(busy_w[0]),
        .overrun_count(ovr_w[0]), .timeout_count(tmo_w[0])
    );

    sample_scheduler #(.data_width(16), .timeout_cycles(T)) dut_t (
        .clk(clk), .reset(reset), .in_sample(in_sample), .in_valid(in_valid),
        .clear_stats(clear_stats), .eng_sample(eng_sample_w[1]),
        .eng_sample_ready(esr_w[1]), .eng_ready(eng_ready),
        .eng_out_sample(eng_out_sample), .out_sample(out_sample_w[1]),
        .out_valid(ov_w[1]), .bypass(byp_w[1]), .busy(busy_w[1]),
        .overrun_count(ovr_w[1]), .timeout_count(tmo_w[1])
    );

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; clear_stats = 1'b0; eng_ready = 1'b1;
        in_sample = '0; eng_out_sample = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // One transaction: in_valid at cycle 0, engine drops ready at cycle 1+da and
    // raises it at cycle 1+dr; optional extra in_valid at xiv, clear_stats at clr.
    task automatic run_txn(input logic [15:0] s, input logic [15:0] res,
                           input int da, input int dr, input int xiv,
                           input logic [15:0] xs, input int clr, input int ncyc,
                           output int iss, output logic [15:0] es_iss,
                           output int ovc, output int ovn,
                           output logic [15:0] ovs, output logic ovb);
        iss = -1; es_iss = '0; ovc = -1; ovn = 0; ovs = '0; ovb = 1'b0;
        eng_out_sample = res;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            if (esr_w[sel] && iss < 0) begin iss = c; es_iss = eng_sample_w[sel]; end
            if (ov_w[sel]) begin ovn++; ovc = c; ovs = out_sample_w[sel]; ovb = byp_w[sel]; end
            in_valid    = (c == 0) || (c == xiv);
            in_sample   = (c == 0) ? s : xs;
            clear_stats = (c == clr);
            eng_ready   = !(c >= 1 + da && c < 1 + dr);
        end
        in_valid = 1'b0; clear_stats = 1'b0; eng_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            sel = s;
            n_total++; if (eng_sample_w[sel] !== 16'h0) $display("FAIL rst_eng_sample[%0d]: got %h want 0000", s, eng_sample_w[sel]); else n_pass++;
            n_total++; if (esr_w[sel] !== 1'b0) $display("FAIL rst_eng_ready_pulse[%0d]: got %b want 0", s, esr_w[sel]); else n_pass++;
            n_total++; if (out_sample_w[sel] !== 16'h0) $display("FAIL rst_out_sample[%0d]: got %h want 0000", s, out_sample_w[sel]); else n_pass++;
            n_total++; if (ov_w[sel] !== 1'b0) $display("FAIL rst_out_valid[%0d]: got %b want 0", s, ov_w[sel]); else n_pass++;
            n_total++; if (byp_w[sel] !== 1'b0) $display("FAIL rst_bypass[%0d]: got %b want 0", s, byp_w[sel]); else n_pass++;
            n_total++; if (busy_w[sel] !== 1'b0) $display("FAIL rst_busy[%0d]: got %b want 0", s, busy_w[sel]); else n_pass++;
            n_total++; if (ovr_w[sel] !== 16'h0) $display("FAIL rst_overrun[%0d]: got %h want 0000", s, ovr_w[sel]); else n_pass++;
            n_total++; if (tmo_w[sel] !== 16'h0) $display("FAIL rst_timeout[%0d]: got %h want 0000", s, tmo_w[sel]); else n_pass++;
        end
        do_reset();
    endtask

    task automatic test_normal();
        int iss, ovc, ovn; logic [15:0] es, ovs; logic ovb;
        sel = 0; do_reset();
        // clear_stats mid-flight must leave the transaction untouched
        run_txn(16'h1234, 16'h0ABC, 2, 12, -1, 16'h0, 5, 20, iss, es, ovc, ovn, ovs, ovb);
        n_total++; if (iss !== 1) $display("FAIL normal_issue_cycle: got %0d want 1", iss); else n_pass++;
        n_total++; if (es !== 16'h1234) $display("FAIL normal_eng_sample: got %h want 1234", es); else n_pass++;
        n_total++; if (ovn !== 1) $display("FAIL normal_out_valid_count: got %0d want 1", ovn); else n_pass++;
        n_total++; if (ovc !== 14) $display("FAIL normal_out_cycle: got %0d want 14", ovc); else n_pass++;
        n_total++; if (ovs !== 16'h0ABC) $display("FAIL normal_out_sample: got %h want 0abc", ovs); else n_pass++;
        n_total++; if (ovb !== 1'b0) $display("FAIL normal_bypass: got %b want 0", ovb); else n_pass++;
        n_total++; if (busy_w[sel] !== 1'b0) $display("FAIL normal_busy_after: got %b want 0", busy_w[sel]); else n_pass++;
        n_total++; if (out_sample_w[sel] !== 16'h0ABC) $display("FAIL normal_out_hold: got %h want 0abc", out_sample_w[sel]); else n_pass++;
    endtask

    task automatic test_timeout();
        int iss, ovc, ovn; logic [15:0] es, ovs; logic ovb;
        sel = 1; do_reset();
        run_txn(16'h8001, 16'h7777, 1000, 1000, -1, 16'h0, -1, 20, iss, es, ovc, ovn, ovs, ovb);
        n_total++; if (iss !== 1) $display("FAIL tmo_issue_cycle: got %0d want 1", iss); else n_pass++;
        n_total++; if (ovn !== 1) $display("FAIL tmo_out_valid_count: got %0d want 1", ovn); else n_pass++;
        n_total++; if (ovc !== 1 + 9) $display("FAIL tmo_out_cycle: got %0d want 10", ovc); else n_pass++;
        n_total++; if (ovs !== 16'h8001) $display("FAIL tmo_out_sample: got %h want 8001", ovs); else n_pass++;
        n_total++; if (ovb !== 1'b1) $display("FAIL tmo_bypass: got %b want 1", ovb); else n_pass++;
        n_total++; if (tmo_w[sel] !== 16'd1) $display("FAIL tmo_count: got %0d want 1", tmo_w[sel]); else n_pass++;
        n_total++; if (byp_w[sel] !== 1'b1) $display("FAIL tmo_bypass_hold: got %b want 1", byp_w[sel]); else n_pass++;
    endtask

    task automatic test_overrun();
        int iss, ovc, ovn; logic [15:0] es, ovs; logic ovb;
        sel = 0; do_reset();
        run_txn(16'h1111, 16'h2468, 2, 12, 6, 16'h5555, -1, 20, iss, es, ovc, ovn, ovs, ovb);
        n_total++; if (ovr_w[sel] !== 16'd1) $display("FAIL ovr_count: got %0d want 1", ovr_w[sel]); else n_pass++;
        n_total++; if (eng_sample_w[sel] !== 16'h1111) $display("FAIL ovr_eng_sample: got %h want 1111", eng_sample_w[sel]); else n_pass++;
        n_total++; if (ovn !== 1) $display("FAIL ovr_out_valid_count: got %0d want 1", ovn); else n_pass++;
        n_total++; if (ovs !== 16'h2468) $display("FAIL ovr_out_sample: got %h want 2468", ovs); else n_pass++;
    endtask

    task automatic test_coincident();
        int iss, ovc, ovn; logic [15:0] es, ovs; logic ovb;
        sel = 1; do_reset();
        // ready rises at cycle 9, where the wait counter sits at T-1
        run_txn(16'h0F0F, 16'hC0DE, 2, T, -1, 16'h0, -1, 16, iss, es, ovc, ovn, ovs, ovb);
        n_total++; if (ovc !== T + 2) $display("FAIL coin_out_cycle: got %0d want %0d", ovc, T + 2); else n_pass++;
        n_total++; if (ovs !== 16'hC0DE) $display("FAIL coin_out_sample: got %h want c0de", ovs); else n_pass++;
        n_total++; if (ovb !== 1'b0) $display("FAIL coin_bypass: got %b want 0", ovb); else n_pass++;
        n_total++; if (tmo_w[sel] !== 16'd0) $display("FAIL coin_timeout_count: got %0d want 0", tmo_w[sel]); else n_pass++;
        // one cycle later is a miss
        run_txn(16'h0F0F, 16'hC0DE, 2, T + 1, -1, 16'h0, -1, 16, iss, es, ovc, ovn, ovs, ovb);
        n_total++; if (ovb !== 1'b1) $display("FAIL late_bypass: got %b want 1", ovb); else n_pass++;
        n_total++; if (ovs !== 16'h0F0F) $display("FAIL late_out_sample: got %h want 0f0f", ovs); else n_pass++;
        n_total++; if (tmo_w[sel] !== 16'd1) $display("FAIL late_timeout_count: got %0d want 1", tmo_w[sel]); else n_pass++;
    endtask

    task automatic test_random();
        int iss, ovc, ovn, da, dr, xiv, e_c, exp_tmo, exp_ovr;
        logic [15:0] es, ovs, s, res, e_s; logic ovb, e_b;
        sel = 1; do_reset();
        exp_tmo = 0; exp_ovr = 0;
        for (int i = 0; i < 24; i++) begin
            s = 16'($urandom); res = 16'($urandom);
            da = $urandom_range(1, 10);
            if (da == T) da = T + 1;
            dr = da + $urandom_range(1, 8);
            // result counts if the engine finishes within T wait cycles after issue
            if (dr <= T) begin e_c = dr + 2; e_s = res; e_b = 1'b0; end
            else begin e_c = T + 2; e_s = s; e_b = 1'b1; exp_tmo++; end
            xiv = ($urandom_range(0, 1) == 1) ? $urandom_range(1, e_c) : -1;
            if (xiv >= 0) exp_ovr++;
            run_txn(s, res, da, dr, xiv, ~s, -1, 14, iss, es, ovc, ovn, ovs, ovb);
            n_total++; if (ovn !== 1) $display("FAIL rnd%0d_out_valid_count: got %0d want 1", i, ovn); else n_pass++;
            n_total++; if (ovc !== e_c) $display("FAIL rnd%0d_out_cycle: got %0d want %0d", i, ovc, e_c); else n_pass++;
            n_total++; if (ovs !== e_s) $display("FAIL rnd%0d_out_sample: got %h want %h", i, ovs, e_s); else n_pass++;
            n_total++; if (ovb !== e_b) $display("FAIL rnd%0d_bypass: got %b want %b", i, ovb, e_b); else n_pass++;
            n_total++; if (eng_sample_w[sel] !== s) $display("FAIL rnd%0d_eng_sample: got %h want %h", i, eng_sample_w[sel], s); else n_pass++;
            n_total++; if (tmo_w[sel] !== 16'(exp_tmo)) $display("FAIL rnd%0d_timeout_count: got %0d want %0d", i, tmo_w[sel], exp_tmo); else n_pass++;
            n_total++; if (ovr_w[sel] !== 16'(exp_ovr)) $display("FAIL rnd%0d_overrun_count: got %0d want %0d", i, ovr_w[sel], exp_ovr); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int iss, ovc, ovn, seen; logic [15:0] es, ovs; logic ovb;
        sel = 0; do_reset();
        run_txn(16'h2222, 16'h7E57, 2, 5, -1, 16'h0, -1, 10, iss, es, ovc, ovn, ovs, ovb);
        @(posedge clk); #1; in_valid = 1'b1; in_sample = 16'h3333;
        @(posedge clk); #1; in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; eng_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        n_total++; if (busy_w[sel] !== 1'b1) $display("FAIL mid_busy_before: got %b want 1", busy_w[sel]); else n_pass++;
        @(posedge clk); #3; reset = 1'b1; #1;
        n_total++; if (eng_sample_w[sel] !== 16'h0) $display("FAIL mid_eng_sample: got %h want 0000", eng_sample_w[sel]); else n_pass++;
        n_total++; if (out_sample_w[sel] !== 16'h0) $display("FAIL mid_out_sample: got %h want 0000", out_sample_w[sel]); else n_pass++;
        n_total++; if (busy_w[sel] !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy_w[sel]); else n_pass++;
        n_total++; if (ov_w[sel] !== 1'b0) $display("FAIL mid_out_valid: got %b want 0", ov_w[sel]); else n_pass++;
        n_total++; if (byp_w[sel] !== 1'b0) $display("FAIL mid_bypass: got %b want 0", byp_w[sel]); else n_pass++;
        seen = 0;
        repeat (2) begin @(posedge clk); #1; if (ov_w[sel]) seen++; end
        reset = 1'b0; eng_ready = 1'b1;
        repeat (5) begin @(posedge clk); #1; if (ov_w[sel]) seen++; end
        n_total++; if (seen !== 0) $display("FAIL mid_no_out_valid: got %0d pulses want 0", seen); else n_pass++;
        in_valid = 1'b1; in_sample = 16'h4444;
        @(posedge clk); #1; in_valid = 1'b0;
        n_total++; if (esr_w[sel] !== 1'b1) $display("FAIL mid_reissue_pulse: got %b want 1", esr_w[sel]); else n_pass++;
        n_total++; if (eng_sample_w[sel] !== 16'h4444) $display("FAIL mid_reissue_sample: got %h want 4444", eng_sample_w[sel]); else n_pass++;
    endtask

    task automatic test_saturation();
        sel = 0; do_reset();
        in_valid = 1'b1; eng_ready = 1'b1;
        // ~1026 of every 1027 cycles are busy, so this far exceeds 65535 drops
        repeat (66000) @(posedge clk);
        #1;
        n_total++; if (ovr_w[sel] !== 16'hFFFF) $display("FAIL sat_overrun: got %h want ffff", ovr_w[sel]); else n_pass++;
        @(posedge clk); #1;
        n_total++; if (ovr_w[sel] !== 16'hFFFF) $display("FAIL sat_no_wrap: got %h want ffff", ovr_w[sel]); else n_pass++;
        clear_stats = 1'b1;
        @(posedge clk); #1;
        clear_stats = 1'b0; in_valid = 1'b0;
        n_total++; if (ovr_w[sel] !== 16'h0) $display("FAIL clr_overrun: got %h want 0000", ovr_w[sel]); else n_pass++;
        n_total++; if (tmo_w[sel] !== 16'h0) $display("FAIL clr_timeout: got %h want 0000", tmo_w[sel]); else n_pass++;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_normal();
        test_timeout();
        test_overrun();
        test_coincident();
        test_random();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
